// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target (7-bit address) with byte-level read/write handshake
// Purpose: synchronises SCL/SDA, detects START/STOP, runs the target byte FSM
//          and drives SDA open-drain for ACKs and read data.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   i2c_scl, i2c_sda     bus clock (input only) and open-drain data
//   tx_data, tx_taken    byte for reads; pulse when it is latched
//   ack_en               ACK (1) / NACK (0) written data bytes
//   rx_data, rx_valid    last written byte; pulse when it updates
//   addressed, rw        address match level and its R/W bit
//   start_det, stop_det  START/repeated START and STOP pulses
//   ctrl_nack            pulse when the controller NACKs a read byte
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  input  logic [7:0] tx_data,
  output logic       tx_taken,
  input  logic       ack_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addressed,
  output logic       rw,
  output logic       start_det,
  output logic       stop_det,
  output logic       ctrl_nack
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_h, sda_h, scl_s, sda_s;
  logic scl_rise, scl_fall, start_cond, stop_cond;

  state_t     state, state_d;
  logic [7:0] shift, shift_d, rx_data_d;
  logic [3:0] cnt, cnt_d;
  logic       sda_oe, sda_oe_d, addressed_d, rw_d, ack_bit, ack_bit_d;
  logic       tx_taken_d, rx_valid_d, start_d, stop_d, ctrl_nack_d;

  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise = ~scl_h & scl_s;
  assign scl_fall = scl_h & ~scl_s;
  // SCL must be high in both samples, so an SDA edge coincident with an
  // SCL edge is ordinary data rather than a bus condition.
  assign start_cond = scl_h & scl_s & sda_h & ~sda_s;
  assign stop_cond  = scl_h & scl_s & ~sda_h & sda_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_h     <= 1'b1;
      sda_h     <= 1'b1;
      state     <= IDLE;
      shift     <= 8'h00;
      cnt       <= 4'd0;
      sda_oe    <= 1'b0;
      addressed <= 1'b0;
      rw        <= 1'b0;
      rx_data   <= 8'h00;
      ack_bit   <= 1'b0;
      tx_taken  <= 1'b0;
      rx_valid  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      ctrl_nack <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
      scl_h     <= scl_s;
      sda_h     <= sda_s;
      state     <= state_d;
      shift     <= shift_d;
      cnt       <= cnt_d;
      sda_oe    <= sda_oe_d;
      addressed <= addressed_d;
      rw        <= rw_d;
      rx_data   <= rx_data_d;
      ack_bit   <= ack_bit_d;
      tx_taken  <= tx_taken_d;
      rx_valid  <= rx_valid_d;
      start_det <= start_d;
      stop_det  <= stop_d;
      ctrl_nack <= ctrl_nack_d;
    end
  end

  always_comb begin
    state_d     = state;
    shift_d     = shift;
    cnt_d       = cnt;
    sda_oe_d    = sda_oe;
    addressed_d = addressed;
    rw_d        = rw;
    rx_data_d   = rx_data;
    ack_bit_d   = ack_bit;
    tx_taken_d  = 1'b0;
    rx_valid_d  = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    ctrl_nack_d = 1'b0;

    if (start_cond) begin
      state_d     = ADDR;
      cnt_d       = 4'd0;
      addressed_d = 1'b0;
      sda_oe_d    = 1'b0;
      start_d     = 1'b1;
    end else if (stop_cond) begin
      state_d     = IDLE;
      addressed_d = 1'b0;
      sda_oe_d    = 1'b0;
      stop_d      = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise && cnt != 4'd8) begin
            shift_d = {shift[6:0], sda_s};
            cnt_d   = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            if (shift[7:1] == TARGET_ADDR) begin
              addressed_d = 1'b1;
              rw_d        = shift[0];
              sda_oe_d    = 1'b1;
              state_d     = ADDR_ACK;
            end else begin
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!rw) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = WR_BYTE;
            end else begin
              // Bit 7 goes out now, so the counter starts at one bit driven.
              shift_d    = tx_data;
              tx_taken_d = 1'b1;
              sda_oe_d   = ~tx_data[7];
              cnt_d      = 4'd1;
              state_d    = RD_BYTE;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise && cnt != 4'd8) begin
            shift_d = {shift[6:0], sda_s};
            cnt_d   = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            rx_data_d  = shift;
            rx_valid_d = 1'b1;
            sda_oe_d   = ack_en;
            state_d    = WR_ACK;
          end
        end
        WR_ACK: begin
          // sda_oe still holds the ACK decision taken at the end of the byte.
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = sda_oe ? WR_BYTE : IDLE;
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              shift_d  = {shift[6:0], 1'b0};
              sda_oe_d = ~shift[6];
              cnt_d    = cnt + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ack_bit_d = sda_s;
          end else if (scl_fall) begin
            if (!ack_bit) begin
              shift_d    = tx_data;
              tx_taken_d = 1'b1;
              sda_oe_d   = ~tx_data[7];
              cnt_d      = 4'd1;
              state_d    = RD_BYTE;
            end else begin
              ctrl_nack_d = 1'b1;
              sda_oe_d    = 1'b0;
              state_d     = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed bench for i2c_target acting as bus controller
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       tb_sda_low;
  logic [7:0] tx_data;
  logic       ack_en;
  logic       tx_taken, rx_valid, addressed, rw, start_det, stop_det, ctrl_nack;
  logic [7:0] rx_data;
  wire        sda;

  int tests = 0;
  int fails = 0;
  int n_start = 0, n_stop = 0, n_rxv = 0, n_txt = 0, n_nack = 0;

  assign sda = tb_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_target #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .i2c_scl(scl), .i2c_sda(sda),
    .tx_data(tx_data), .tx_taken(tx_taken), .ack_en(ack_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .addressed(addressed), .rw(rw),
    .start_det(start_det), .stop_det(stop_det), .ctrl_nack(ctrl_nack)
  );

  always @(negedge clk) begin
    if (start_det) n_start <= n_start + 1;
    if (stop_det)  n_stop  <= n_stop + 1;
    if (rx_valid)  n_rxv   <= n_rxv + 1;
    if (tx_taken)  n_txt   <= n_txt + 1;
    if (ctrl_nack) n_nack  <= n_nack + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (10) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic r);
    tb_sda_low = ~b;
    wait_q();
    scl = 1'b1;
    wait_q();
    r = sda;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic bus_start();
    tb_sda_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    tb_sda_low = 1'b1;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic bus_stop();
    tb_sda_low = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    tb_sda_low = 1'b0;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
    clk_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      d[i] = r;
    end
    clk_bit(~ack, r);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         s0, v0, t0;

    reset = 1'b1; scl = 1'b1; tb_sda_low = 1'b0; tx_data = 8'h00; ack_en = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_addressed", {7'd0, addressed}, 8'h00);
    check("rst_rw", {7'd0, rw}, 8'h00);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {3'd0, tx_taken, rx_valid, start_det, stop_det, ctrl_nack}, 8'h00);
    check("rst_sda", {7'd0, sda}, 8'h01);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Write 0xA0, 0x3C with ACKs, then STOP
    bus_start();
    check("wr_start_det", n_start[7:0], 8'd1);
    write_byte(8'hA0, ack);
    check("wr_addr_ack", {7'd0, ack}, 8'h01);
    check("wr_addressed", {7'd0, addressed}, 8'h01);
    check("wr_rw", {7'd0, rw}, 8'h00);
    write_byte(8'h3C, ack);
    check("wr_data_ack", {7'd0, ack}, 8'h01);
    check("wr_rxv_count", n_rxv[7:0], 8'd1);
    check("wr_rx_data", rx_data, 8'h3C);
    bus_stop();
    check("wr_stop_det", n_stop[7:0], 8'd1);
    check("wr_unaddressed", {7'd0, addressed}, 8'h00);

    // Read 0x96 then 0x5A, controller ACK then NACK
    tx_data = 8'h96;
    bus_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", {7'd0, ack}, 8'h01);
    check("rd_rw", {7'd0, rw}, 8'h01);
    tx_data = 8'h5A;
    read_byte(1'b1, d);
    check("rd_byte0", d, 8'h96);
    read_byte(1'b0, d);
    check("rd_byte1", d, 8'h5A);
    check("rd_tx_taken", n_txt[7:0], 8'd2);
    check("rd_ctrl_nack", n_nack[7:0], 8'd1);
    bus_stop();

    // Wrong address: no ACK, nothing happens
    v0 = n_rxv;
    bus_start();
    write_byte(8'hA2, ack);
    check("bad_addr_nack", {7'd0, ack}, 8'h00);
    check("bad_addressed", {7'd0, addressed}, 8'h00);
    write_byte(8'h12, ack);
    check("bad_no_rxv", n_rxv[7:0], v0[7:0]);
    bus_stop();

    // Data byte NACKed when ack_en=0; target then ignores the bus
    bus_start();
    write_byte(8'hA0, ack);
    check("nak_addr_ack", {7'd0, ack}, 8'h01);
    ack_en = 1'b0;
    write_byte(8'h55, ack);
    check("nak_data_nack", {7'd0, ack}, 8'h00);
    check("nak_rx_data", rx_data, 8'h55);
    v0 = n_rxv;
    ack_en = 1'b1;
    write_byte(8'h11, ack);
    check("nak_idle_nack", {7'd0, ack}, 8'h00);
    check("nak_idle_no_rxv", n_rxv[7:0], v0[7:0]);
    bus_start();
    write_byte(8'hA0, ack);
    check("nak_readdress", {7'd0, ack}, 8'h01);
    bus_stop();

    // Repeated START after 4 data bits, then read
    bus_start();
    write_byte(8'hA0, ack);
    clk_bit(1'b1, r);
    clk_bit(1'b0, r);
    clk_bit(1'b1, r);
    clk_bit(1'b1, r);
    s0 = n_start;
    bus_start();
    check("rs_start_det", n_start[7:0], s0[7:0] + 8'd1);
    check("rs_unaddressed", {7'd0, addressed}, 8'h00);
    tx_data = 8'hC3;
    write_byte(8'hA1, ack);
    check("rs_addr_ack", {7'd0, ack}, 8'h01);
    check("rs_rw", {7'd0, rw}, 8'h01);
    read_byte(1'b0, d);
    check("rs_read", d, 8'hC3);
    bus_stop();

    // Reset while the target is driving a read 0 bit
    tx_data = 8'h00;
    bus_start();
    write_byte(8'hA1, ack);
    check("rr_sda_driven", {7'd0, sda}, 8'h00);
    t0 = n_txt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rr_sda_released", {7'd0, sda}, 8'h01);
    @(negedge clk);
    check("rr_addressed", {7'd0, addressed}, 8'h00);
    clk_bit(1'b1, r);
    check("rr_bus_ignored", {7'd0, r}, 8'h01);
    check("rr_no_tx_taken", n_txt[7:0], t0[7:0]);
    bus_stop();
    bus_start();
    write_byte(8'hA0, ack);
    check("rr_addr_ack", {7'd0, ack}, 8'h01);
    write_byte(8'h77, ack);
    check("rr_data_ack", {7'd0, ack}, 8'h01);
    check("rr_rx_data", rx_data, 8'h77);
    bus_stop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL provide parameter TARGET_ADDR, default 7'h50, 7-bit address this target responds to.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, number of synchroniser flops on SCL and SDA; legal range 2-4.
REQ-003 SHALL provide port clk  input  1  system clock, at least 20x the SCL frequency.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port i2c_scl  input  1  bus clock; no clock stretching.
REQ-006 SHALL provide port i2c_sda  inout  1  open-drain data; driven 0 when sda_oe=1, else high-Z.
REQ-007 SHALL provide port tx_data  input  8  byte returned to the controller on reads.
REQ-008 SHALL provide port tx_taken  output  1  one-cycle pulse: tx_data was latched into the shift register.
REQ-009 SHALL provide port ack_en  input  1  ACK (1) or NACK (0) controller-written data bytes.
REQ-010 SHALL provide port rx_data  output  8  last received data byte.
REQ-011 SHALL provide port rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-012 SHALL provide port addressed  output  1  level: an address match is active.
REQ-013 SHALL provide port rw  output  1  R/W bit of the matched address: 1 read, 0 write.
REQ-014 SHALL provide port start_det  output  1  one-cycle pulse on START or repeated START.
REQ-015 SHALL provide port stop_det  output  1  one-cycle pulse on STOP.
REQ-016 SHALL provide port ctrl_nack  output  1  one-cycle pulse: controller NACKed a read byte.

Function
REQ-017 SHALL pass SCL and SDA through SYNC_STAGES flops, plus one history flop each for edge detection.
REQ-018 SHALL define an SCL rise as history 0 and synchronised 1, and an SCL fall as the reverse.
REQ-019 SHALL detect START when SDA falls while SCL is high in both the history and synchronised samples.
REQ-020 SHALL detect STOP when SDA rises while SCL is high in both the history and synchronised samples.
REQ-021 SHALL treat an SDA change in the same clk cycle as an SCL change as data, not as START or STOP.
REQ-022 SHALL sample SDA only on SCL rise, and change sda_oe only on SCL fall or on START/STOP/reset.
REQ-023 SHALL use the FSM states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
REQ-024 SHALL enter ADDR from any state on START, clearing the bit counter, addressed and sda_oe.
REQ-025 SHALL enter IDLE from any state on STOP, clearing addressed and sda_oe.
REQ-026 ADDR SHALL shift 8 bits MSB-first; on the 8th SCL fall, if bits[7:1]==TARGET_ADDR, it SHALL:
- set addressed and rw;
- set sda_oe=1;
- enter ADDR_ACK.
REQ-027 On an address mismatch, including general call 0x00, ADDR SHALL enter IDLE and never drive SDA.
REQ-028 On the SCL fall ending ADDR_ACK, the FSM SHALL:
- if rw=0: release SDA and enter WR_BYTE;
- if rw=1: load tx_data, pulse tx_taken, drive bit7 and enter RD_BYTE.
REQ-029 WR_BYTE SHALL shift 8 bits; on the 8th SCL fall it SHALL:
- update rx_data and pulse rx_valid;
- set sda_oe=ack_en;
- enter WR_ACK.
REQ-030 On the SCL fall ending WR_ACK, the FSM SHALL release SDA and enter WR_BYTE when ack_en was 1, otherwise IDLE.
REQ-031 RD_BYTE SHALL drive sda_oe=~shift[7] and shift on each SCL fall; after the 8th bit it SHALL release SDA and enter RD_ACK.
REQ-032 RD_ACK SHALL sample SDA on SCL rise, then act on the following SCL fall:
- SDA=0: load tx_data, pulse tx_taken, enter RD_BYTE;
- SDA=1: pulse ctrl_nack, enter IDLE with SDA released.
REQ-033 The bit counter SHALL be 4 bits and SHALL reset to 0 at each byte start; it SHALL never wrap within a byte.
REQ-034 START/STOP pulses SHALL assert the cycle after detection.
REQ-035 rx_valid and tx_taken SHALL assert the cycle after the qualifying SCL fall.

Reset
REQ-036 During reset the block SHALL hold:
- FSM=IDLE, sda_oe=0, shift register and counter=0;
- rx_data=8'h00, addressed=0, rw=0;
- all pulses=0;
- synchronisers and history flops=1.
REQ-037 Reset asserted mid-transfer SHALL release SDA on the next clk edge and ignore the bus until the next START.

Verification
REQ-038 Write 0xA0, 0x3C with ack_en=1 -> both bytes ACKed; rx_valid once with rx_data=0x3C; STOP -> stop_det, addressed=0.
REQ-039 Read 0xA1 with tx_data=0x96, then 0x5A, controller ACK then NACK -> bus reads 0x96, 0x5A; tx_taken twice; ctrl_nack once.
REQ-040 Address 0xA2 -> no ACK (SDA high at bit 9), addressed stays 0, no rx_valid.
REQ-041 Write 0xA0 with ack_en=0 on the data byte -> data byte NACKed, FSM in IDLE, next START re-addresses correctly.
REQ-042 Repeated START after 4 bits of a write, then 0xA1 -> start_det pulses, SDA released, read proceeds with rw=1.
REQ-043 Reset pulsed while driving a read 0 bit -> SDA released next cycle; subsequent full transfer passes.
